eth_tx_framer: RTL and testbench
================================

ETH_TX_FRAMER -- requirements
Module: eth_tx_framer

Interface
REQ-001 SHALL have parameter MIN_WORDS, default 15, minimum payload words before FCS (60 bytes).
REQ-002 SHALL have parameter MAX_WORDS, default 378, maximum payload words accepted per frame.
REQ-003 SHALL have parameter CRC_LATENCY, default 2, cycles from the last CRC word to a valid crc_in.
REQ-004 SHALL have parameter IFG_CYCLES, default 3, idle cycles after FCS (12 byte times).
REQ-005 SHALL use one clock and a synchronous, active-low reset: clk  input  1  rising-edge clock; rst_n  input  1  reset.
REQ-006 s_data  input  32  payload word; s_valid  input  1; s_last  input  1  final payload word; s_ready  output  1.
REQ-007 tx_data  output  32  line word; tx_valid  output  1; tx_ready  input  1  sink accepts; tx_sof  output  1  first preamble word; tx_eof  output  1  FCS word.
REQ-008 crc_init  output  1  one-cycle CRC restart; crc_data  output  32; crc_valid  output  1; crc_en  output  1; crc_in  input  32  CRC result.
REQ-009 busy  output  1  frame in progress; frame_err  output  1  one-cycle oversize pulse.

Function
REQ-010 SHALL implement states IDLE, PRE0, PRE1, DATA, PAD, CRC_WAIT, FCS, IFG.
REQ-011 IDLE -> PRE0 when s_valid=1; crc_init SHALL pulse for one cycle on that transition.
REQ-012 PRE0 SHALL drive 0x55555555 with tx_sof=1; PRE1 SHALL drive 0x555555D5; each advances only on tx_valid&tx_ready.
REQ-013 DATA: s_ready = tx_ready; tx_data = s_data; tx_valid = s_valid; a word is transferred when s_valid&tx_ready.
REQ-014 Every transferred DATA or PAD word SHALL appear on crc_data in the same cycle with crc_valid=crc_en=1; preamble, FCS and IFG words SHALL NOT be presented to the CRC.
REQ-015 A 9-bit word counter SHALL count transferred payload+pad words, cleared on entry to PRE0.
REQ-016 DATA with s_last transferred: -> PAD if count (including that word) < MIN_WORDS, else -> CRC_WAIT.
REQ-017 PAD SHALL drive 0x00000000 words until count = MIN_WORDS, then -> CRC_WAIT.
REQ-018 Oversize: if a transfer in DATA makes count = MAX_WORDS without s_last, frame_err SHALL pulse, and s_ready SHALL be 1 (words dropped, not transmitted, not CRC-fed) until s_last is consumed; then -> CRC_WAIT. s_last on exactly word MAX_WORDS is a normal frame.
REQ-019 CRC_WAIT SHALL hold tx_valid=0 for CRC_LATENCY cycles, then sample crc_in and -> FCS.
REQ-020 FCS SHALL drive ~crc_in (sampled value) with tx_eof=1; on tx_ready -> IFG.
REQ-021 IFG SHALL hold tx_valid=0 and s_ready=0 for IFG_CYCLES cycles, then -> IDLE.
REQ-022 With tx_valid=1 and tx_ready=0, tx_data, tx_sof, tx_eof and state SHALL hold stable.
REQ-023 s_ready SHALL be 0 in every state except DATA and the drop mode of REQ-018.
REQ-024 busy SHALL be 1 in every state except IDLE.

Reset
REQ-025 rst_n=0 sampled at a clk edge SHALL force IDLE, counters 0, and all outputs 0, including mid-frame (no FCS emitted, frame abandoned).
REQ-026 First frame after reset SHALL start no earlier than the first cycle with rst_n=1.

Structure
REQ-027 State encoding, preamble/SFD constants and the 60/1514-byte limits SHALL live in shared package eth_pkg.
REQ-028 SHALL be a single FSM module; crc_generator is instantiated by the parent, not inside this block.

Verification
REQ-029 20-word frame, tx_ready=1: 0x55555555(sof), 0x555555D5, 20 data words, gap of 2, ~crc_in (eof), 3 idle cycles; crc_valid exactly 20 cycles.
REQ-030 4-word frame: 4 data words then 11 zero pad words; crc_valid 15 cycles; FCS follows.
REQ-031 380-word input without earlier s_last: 378 words transmitted, frame_err pulses once, words 379-380 dropped, FCS appended.
REQ-032 tx_ready toggled 0/1 every cycle on 16-word frame: no word lost or duplicated, tx_data stable while stalled.
REQ-033 rst_n=0 for 1 cycle during DATA word 7: next cycle all outputs 0, state IDLE; next frame begins with clean preamble and crc_init.

Source files
------------

// File: rtl/eth_pkg.sv
// Shared Ethernet framing constants and the framer state encoding.
// Frame-size limits are held in bytes; the word counts are derived from them.
package eth_pkg;

  typedef enum logic [2:0] {
    IDLE,
    PRE0,
    PRE1,
    DATA,
    PAD,
    CRC_WAIT,
    FCS,
    IFG
  } state_e;

  localparam int          WORD_W          = 32;
  localparam int          BYTES_PER_WORD  = WORD_W / 8;
  localparam logic [31:0] PREAMBLE_WORD   = 32'h5555_5555;
  localparam logic [31:0] SFD_WORD        = 32'h5555_55D5;
  localparam int          MIN_FRAME_BYTES = 60;
  localparam int          MAX_FRAME_BYTES = 1514;
  localparam int          MIN_WORDS_DEF   = MIN_FRAME_BYTES / BYTES_PER_WORD;
  // 1514 / 4 truncates to 378 whole words.
  localparam int          MAX_WORDS_DEF   = MAX_FRAME_BYTES / BYTES_PER_WORD;
  localparam int          CNT_W           = 9;

endpackage

// File: rtl/eth_tx_framer_if.sv
// Payload stream, line stream, CRC-engine side channel and status of the framer.
// master = the framer itself, slave = everything around it.
interface eth_tx_framer_if;
  import eth_pkg::*;

  logic [WORD_W-1:0] s_data;
  logic              s_valid;
  logic              s_last;
  logic              s_ready;

  logic [WORD_W-1:0] tx_data;
  logic              tx_valid;
  logic              tx_ready;
  logic              tx_sof;
  logic              tx_eof;

  logic              crc_init;
  logic [WORD_W-1:0] crc_data;
  logic              crc_valid;
  logic              crc_en;
  logic [WORD_W-1:0] crc_in;

  logic              busy;
  logic              frame_err;

  modport master (
    input  s_data, s_valid, s_last, tx_ready, crc_in,
    output s_ready, tx_data, tx_valid, tx_sof, tx_eof,
           crc_init, crc_data, crc_valid, crc_en, busy, frame_err
  );

  modport slave (
    output s_data, s_valid, s_last, tx_ready, crc_in,
    input  s_ready, tx_data, tx_valid, tx_sof, tx_eof,
           crc_init, crc_data, crc_valid, crc_en, busy, frame_err
  );

endinterface

// File: rtl/eth_tx_framer.sv
// Wraps a payload word stream with preamble/SFD, zero padding and an FCS word.
// The CRC engine lives outside; this block only feeds it and samples its result.
module eth_tx_framer
  import eth_pkg::*;
#(
  parameter int MIN_WORDS   = MIN_WORDS_DEF,
  parameter int MAX_WORDS   = MAX_WORDS_DEF,
  parameter int CRC_LATENCY = 2,
  parameter int IFG_CYCLES  = 3
) (
  input  logic            clk,
  input  logic            rst_n,
  eth_tx_framer_if.master bus
);

  localparam int WAIT_MAX = (CRC_LATENCY > IFG_CYCLES) ? CRC_LATENCY : IFG_CYCLES;
  localparam int WAIT_W   = $clog2(WAIT_MAX + 1);

  localparam logic [CNT_W-1:0]  MIN_CNT  = CNT_W'(MIN_WORDS);
  localparam logic [CNT_W-1:0]  MAX_CNT  = CNT_W'(MAX_WORDS);
  localparam logic [WAIT_W-1:0] CRC_LAST = WAIT_W'(CRC_LATENCY - 1);
  localparam logic [WAIT_W-1:0] IFG_LAST = WAIT_W'(IFG_CYCLES - 1);

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [WAIT_W-1:0]   wait_q, wait_d;
  logic [WORD_W-1:0]   fcs_q, fcs_d;
  logic                drop_q, drop_d;
  logic                crc_init_q, crc_init_d;
  logic                frame_err_q, frame_err_d;

  logic                s_ready_c;
  logic [WORD_W-1:0]   tx_data_c;
  logic                tx_valid_c;
  logic                tx_sof_c;
  logic                tx_eof_c;
  logic [WORD_W-1:0]   crc_data_c;
  logic                crc_valid_c;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    wait_d      = wait_q;
    fcs_d       = fcs_q;
    drop_d      = drop_q;
    crc_init_d  = 1'b0;
    frame_err_d = 1'b0;
    s_ready_c   = 1'b0;
    tx_data_c   = '0;
    tx_valid_c  = 1'b0;
    tx_sof_c    = 1'b0;
    tx_eof_c    = 1'b0;
    crc_data_c  = '0;
    crc_valid_c = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (bus.s_valid) begin
          state_d    = PRE0;
          cnt_d      = '0;
          drop_d     = 1'b0;
          crc_init_d = 1'b1;
        end
      end
      PRE0: begin
        tx_valid_c = 1'b1;
        tx_data_c  = PREAMBLE_WORD;
        tx_sof_c   = 1'b1;
        if (bus.tx_ready) state_d = PRE1;
      end
      PRE1: begin
        tx_valid_c = 1'b1;
        tx_data_c  = SFD_WORD;
        if (bus.tx_ready) state_d = DATA;
      end
      DATA: begin
        if (drop_q) begin
          // Oversize tail: swallow input words until the frame's last word.
          s_ready_c = 1'b1;
          if (bus.s_valid && bus.s_last) begin
            state_d = CRC_WAIT;
            wait_d  = '0;
          end
        end else begin
          s_ready_c  = bus.tx_ready;
          tx_valid_c = bus.s_valid;
          tx_data_c  = bus.s_data;
          if (bus.s_valid && bus.tx_ready) begin
            crc_valid_c = 1'b1;
            crc_data_c  = bus.s_data;
            cnt_d       = cnt_q + 1'b1;
            if (bus.s_last) begin
              state_d = (cnt_d < MIN_CNT) ? PAD : CRC_WAIT;
              wait_d  = '0;
            end else if (cnt_d == MAX_CNT) begin
              drop_d      = 1'b1;
              frame_err_d = 1'b1;
            end
          end
        end
      end
      PAD: begin
        tx_valid_c = 1'b1;
        if (bus.tx_ready) begin
          crc_valid_c = 1'b1;
          cnt_d       = cnt_q + 1'b1;
          if (cnt_d == MIN_CNT) begin
            state_d = CRC_WAIT;
            wait_d  = '0;
          end
        end
      end
      CRC_WAIT: begin
        if (wait_q == CRC_LAST) begin
          fcs_d   = ~bus.crc_in;
          state_d = FCS;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      FCS: begin
        tx_valid_c = 1'b1;
        tx_data_c  = fcs_q;
        tx_eof_c   = 1'b1;
        if (bus.tx_ready) begin
          state_d = IFG;
          wait_d  = '0;
        end
      end
      IFG: begin
        if (wait_q == IFG_LAST) state_d = IDLE;
        else                    wait_d  = wait_q + 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      wait_q      <= '0;
      fcs_q       <= '0;
      drop_q      <= 1'b0;
      crc_init_q  <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      wait_q      <= wait_d;
      fcs_q       <= fcs_d;
      drop_q      <= drop_d;
      crc_init_q  <= crc_init_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign bus.s_ready   = s_ready_c;
  assign bus.tx_data   = tx_data_c;
  assign bus.tx_valid  = tx_valid_c;
  assign bus.tx_sof    = tx_sof_c;
  assign bus.tx_eof    = tx_eof_c;
  assign bus.crc_init  = crc_init_q;
  assign bus.crc_data  = crc_data_c;
  assign bus.crc_valid = crc_valid_c;
  assign bus.crc_en    = crc_valid_c;
  assign bus.busy      = (state_q != IDLE);
  assign bus.frame_err = frame_err_q;

endmodule

// File: tb/tb_eth_tx_framer.sv
// Scoreboard bench for eth_tx_framer: the stimulus side queues expected line words,
// a negedge monitor pops and compares them; a stub CRC engine closes the loop.
`timescale 1ns/1ps
module tb_eth_tx_framer;

  localparam int MIN_W = 15;
  localparam int MAX_W = 378;
  localparam int LAT   = 2;
  localparam int IFG_N = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  eth_tx_framer_if bus();

  eth_tx_framer #(
    .MIN_WORDS  (MIN_W),
    .MAX_WORDS  (MAX_W),
    .CRC_LATENCY(LAT),
    .IFG_CYCLES (IFG_N)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  typedef struct packed {
    logic [31:0] data;
    logic        sof;
    logic        eof;
  } word_t;

  typedef struct {
    int crc_cnt;
    int gap;
  } frame_t;

  word_t  exp_q[$];
  frame_t frm_q[$];
  int     errors = 0;
  int     checks = 0;
  int     exp_frame_err = 0;
  int     exp_crc_init = 0;
  int     rdy_mode = 0;
  int     cyc = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] crc_step(input logic [31:0] a, input logic [31:0] d);
    return {a[30:0], a[31]} ^ d ^ 32'h04C1_1DB7;
  endfunction

  // Stub CRC engine: result reflects a fed word LAT cycles later.
  logic [31:0] acc_r = 32'h0;
  logic [31:0] acc_d1 = 32'h0;
  always @(posedge clk) begin
    if (bus.crc_init) acc_r <= 32'hFFFF_FFFF;
    else if (bus.crc_valid && bus.crc_en) acc_r <= crc_step(acc_r, bus.crc_data);
    acc_d1 <= acc_r;
  end
  assign bus.crc_in = acc_d1;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    bus.tx_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      bus.tx_ready = (rdy_mode != 0) ? ~bus.tx_ready : 1'b1;
    end
  end

  // ---------------- monitor ----------------
  word_t       w;
  frame_t      f;
  bit          stalled_prev = 0;
  logic [31:0] prev_data;
  logic [1:0]  prev_flags;
  bit          in_ifg = 0;
  int          ifg_cnt = 0;
  int          crc_cnt_frame = 0;
  int          last_crc_cyc = 0;
  int          crc_init_cnt = 0;
  int          frame_err_cnt = 0;

  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        stalled_prev = 0;
        in_ifg = 0;
        continue;
      end
      if (bus.crc_init) begin
        crc_init_cnt++;
        chk("crc_init_with_sof", bus.tx_sof, 1'b1);
      end
      if (bus.frame_err) frame_err_cnt++;
      if (in_ifg) begin
        if (bus.busy) begin
          ifg_cnt++;
          chk("ifg_quiet", {bus.tx_valid, bus.s_ready}, 2'b00);
        end else begin
          in_ifg = 0;
          chk("ifg_len", ifg_cnt, IFG_N);
        end
      end
      if (stalled_prev) begin
        chk("stall_valid", bus.tx_valid, 1'b1);
        chk("stall_data", bus.tx_data, prev_data);
        chk("stall_flags", {bus.tx_sof, bus.tx_eof}, prev_flags);
      end
      if (bus.crc_valid) begin
        crc_cnt_frame++;
        last_crc_cyc = cyc;
        chk("crc_hs", {bus.tx_valid, bus.tx_ready, bus.crc_en}, 3'b111);
        chk("crc_data", bus.crc_data, bus.tx_data);
      end
      if (bus.tx_valid && bus.tx_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_word: got %h expected none", bus.tx_data);
        end else begin
          w = exp_q.pop_front();
          chk("tx_data", bus.tx_data, w.data);
          chk("tx_flags", {bus.tx_sof, bus.tx_eof}, {w.sof, w.eof});
        end
        if (bus.tx_sof) crc_cnt_frame = 0;
        if (bus.tx_eof) begin
          if (frm_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_eof: got eof expected none");
          end else begin
            f = frm_q.pop_front();
            chk("crc_count", crc_cnt_frame, f.crc_cnt);
            if (f.gap >= 0) chk("fcs_gap", cyc - last_crc_cyc, f.gap);
          end
          in_ifg = 1;
          ifg_cnt = 0;
        end
      end
      stalled_prev = bus.tx_valid && !bus.tx_ready;
      prev_data    = bus.tx_data;
      prev_flags   = {bus.tx_sof, bus.tx_eof};
    end
  end

  // ---------------- stimulus ----------------
  function automatic void push_w(input logic [31:0] d, input logic s, input logic e);
    word_t x;
    x.data = d;
    x.sof  = s;
    x.eof  = e;
    exp_q.push_back(x);
  endfunction

  task automatic send_word(input logic [31:0] d, input logic last);
    bit ok = 0;
    bus.s_data  = d;
    bus.s_valid = 1'b1;
    bus.s_last  = last;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (bus.s_ready) begin
        ok = 1;
        break;
      end
    end
    @(posedge clk);
    #1;
    bus.s_valid = 1'b0;
    bus.s_last  = 1'b0;
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL s_ready_timeout: got 0 expected 1");
    end
  endtask

  task automatic send_frame(input int n, input logic [31:0] base, input int gap);
    logic [31:0] acc = 32'hFFFF_FFFF;
    int sent = 0;
    frame_t fr;
    push_w(32'h5555_5555, 1'b1, 1'b0);
    push_w(32'h5555_55D5, 1'b0, 1'b0);
    for (int i = 0; i < n && i < MAX_W; i++) begin
      push_w(base + i, 1'b0, 1'b0);
      acc = crc_step(acc, base + i);
      sent++;
    end
    while (sent < MIN_W) begin
      push_w(32'h0, 1'b0, 1'b0);
      acc = crc_step(acc, 32'h0);
      sent++;
    end
    push_w(~acc, 1'b0, 1'b1);
    fr.crc_cnt = sent;
    fr.gap     = gap;
    frm_q.push_back(fr);
    if (n > MAX_W) exp_frame_err++;
    exp_crc_init++;
    for (int i = 0; i < n; i++) send_word(base + i, (i == n - 1));
  endtask

  initial begin
    bus.s_data  = '0;
    bus.s_valid = 1'b0;
    bus.s_last  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_outputs", {bus.tx_valid, bus.s_ready, bus.busy, bus.tx_sof, bus.tx_eof,
                          bus.crc_init, bus.crc_valid, bus.crc_en, bus.frame_err}, 9'h0);
    chk("reset_data", bus.tx_data | bus.crc_data, 32'h0);
    // s_valid while still in reset must not start a frame.
    bus.s_valid = 1'b1;
    bus.s_data  = 32'h1000_0000;
    @(posedge clk);
    #1;
    chk("no_start_in_reset", {bus.busy, bus.crc_init}, 2'b00);
    rst_n = 1'b1;

    send_frame(20, 32'h1000_0000, LAT + 1);
    send_frame(4, 32'h2000_0000, LAT + 1);
    send_frame(MIN_W, 32'h3000_0000, LAT + 1);
    send_frame(380, 32'h4000_0000, -1);
    send_frame(MAX_W, 32'h5000_0000, LAT + 1);
    rdy_mode = 1;
    send_frame(16, 32'h6000_0000, -1);
    for (int i = 0; i < 200 && frm_q.size() != 0; i++) @(posedge clk);
    rdy_mode = 0;
    repeat (IFG_N + 4) @(posedge clk);
    #1;

    // Abort a frame with a one-cycle reset while word 7 is on the line.
    exp_crc_init++;
    push_w(32'h5555_5555, 1'b1, 1'b0);
    push_w(32'h5555_55D5, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) push_w(32'h7000_0000 + i, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) send_word(32'h7000_0000 + i, 1'b0);
    bus.s_data  = 32'h7000_0006;
    bus.s_valid = 1'b1;
    rst_n       = 1'b0;
    @(posedge clk);
    #1;
    rst_n       = 1'b1;
    bus.s_valid = 1'b0;
    chk("abort_outputs", {bus.tx_valid, bus.s_ready, bus.busy, bus.tx_sof, bus.tx_eof,
                          bus.crc_init, bus.crc_valid, bus.crc_en, bus.frame_err}, 9'h0);
    chk("abort_data", bus.tx_data | bus.crc_data, 32'h0);
    send_frame(5, 32'h8000_0000, LAT + 1);

    for (int i = 0; i < 400 && exp_q.size() != 0; i++) @(posedge clk);
    repeat (IFG_N + 4) @(posedge clk);
    chk("drain_words", exp_q.size(), 0);
    chk("drain_frames", frm_q.size(), 0);
    chk("frame_err_pulses", frame_err_cnt, exp_frame_err);
    chk("crc_init_pulses", crc_init_cnt, exp_crc_init);
    chk("idle_at_end", bus.busy, 1'b0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1, "watchdog");
  end

endmodule
